// File: rtl/core_pkg.sv
// Shared RV32I core definitions: control-bundle layout, NOP bundle and ALU op codes.
package core_pkg;

   localparam int unsigned ALUOP_W = 4;
   localparam int unsigned CTRL_W  = 7 + ALUOP_W;

   typedef enum logic [ALUOP_W-1:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_SLL   = 4'd2,
      ALU_SLT   = 4'd3,
      ALU_SLTU  = 4'd4,
      ALU_XOR   = 4'd5,
      ALU_SRL   = 4'd6,
      ALU_SRA   = 4'd7,
      ALU_OR    = 4'd8,
      ALU_AND   = 4'd9,
      ALU_PASSB = 4'd10
   } alu_op_e;

   // Bundle is packed MSB-first, so reg_write is bit CTRL_W-1 and alu_op occupies the LSBs.
   typedef struct packed {
      logic    reg_write;
      logic    mem_read;
      logic    mem_write;
      logic    mem_to_reg;
      logic    alu_src;
      logic    branch;
      logic    jump;
      alu_op_e alu_op;
   } ctrl_t;

   localparam int unsigned CTRL_ALUOP_LSB  = 0;
   localparam int unsigned CTRL_JUMP       = ALUOP_W;
   localparam int unsigned CTRL_BRANCH     = ALUOP_W + 1;
   localparam int unsigned CTRL_ALU_SRC    = ALUOP_W + 2;
   localparam int unsigned CTRL_MEM_TO_REG = ALUOP_W + 3;
   localparam int unsigned CTRL_MEM_WRITE  = ALUOP_W + 4;
   localparam int unsigned CTRL_MEM_READ   = ALUOP_W + 5;
   localparam int unsigned CTRL_REG_WRITE  = ALUOP_W + 6;

   localparam ctrl_t CTRL_NOP = ctrl_t'('0);

endpackage

// File: rtl/id_ex_stall_reg_stall_counter.sv
// Saturating up-counter with increment enable; cleared only by reset.
module stall_counter #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_i,
   output logic [CNT_W-1:0] count_o
);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc_i && (count_q != '1)) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

   assign count_o = count_q;

endmodule

// File: rtl/id_ex_stall_reg.sv
// ID/EX pipeline register: holds its entry on a hazard stall, drops it on flush,
// and counts stalled cycles.
module id_ex_stall_reg #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned ALUOP_W = 4,
   parameter int unsigned CNT_W   = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 id_valid,
   input  logic [XLEN-1:0]      id_pc,
   input  logic [4:0]           id_rs1,
   input  logic [4:0]           id_rs2,
   input  logic [4:0]           id_rd,
   input  logic [XLEN-1:0]      id_rs1_data,
   input  logic [XLEN-1:0]      id_rs2_data,
   input  logic [XLEN-1:0]      id_imm,
   input  logic [ALUOP_W+6:0]   id_ctrl,
   input  logic                 hazard_stall,
   input  logic                 flush,
   output logic                 ex_valid,
   output logic [XLEN-1:0]      ex_pc,
   output logic [XLEN-1:0]      ex_rs1_data,
   output logic [XLEN-1:0]      ex_rs2_data,
   output logic [XLEN-1:0]      ex_imm,
   output logic [4:0]           ex_rs1,
   output logic [4:0]           ex_rs2,
   output logic [4:0]           ex_rd,
   output logic [ALUOP_W+6:0]   ex_ctrl,
   output logic                 ex_fire,
   output logic                 stall_if_id,
   output logic [CNT_W-1:0]     stall_cycles
);
   import core_pkg::*;

   localparam int unsigned CW = ALUOP_W + 7;
   localparam logic [CW-1:0] CtrlNop = CW'(CTRL_NOP);

   logic            valid_q;
   logic [XLEN-1:0] pc_q, rs1_data_q, rs2_data_q, imm_q;
   logic [4:0]      rs1_q, rs2_q, rd_q;
   logic [CW-1:0]   ctrl_q;
   logic            stall;

   // A stall against a bubble is ignored so the register keeps filling.
   assign stall       = hazard_stall & valid_q & ~flush;
   assign stall_if_id = stall;
   assign ex_fire     = valid_q & ~hazard_stall & ~flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q    <= 1'b0;
         pc_q       <= '0;
         rs1_data_q <= '0;
         rs2_data_q <= '0;
         imm_q      <= '0;
         rs1_q      <= '0;
         rs2_q      <= '0;
         rd_q       <= '0;
         ctrl_q     <= CtrlNop;
      end else if (flush) begin
         valid_q <= 1'b0;
         ctrl_q  <= CtrlNop;
      end else if (!stall) begin
         valid_q    <= id_valid;
         pc_q       <= id_pc;
         rs1_data_q <= id_rs1_data;
         rs2_data_q <= id_rs2_data;
         imm_q      <= id_imm;
         rs1_q      <= id_rs1;
         rs2_q      <= id_rs2;
         rd_q       <= id_rd;
         ctrl_q     <= id_valid ? id_ctrl : CtrlNop;
      end
   end

   stall_counter #(.CNT_W(CNT_W)) u_stall_counter (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (stall),
      .count_o (stall_cycles)
   );

   assign ex_valid    = valid_q;
   assign ex_pc       = pc_q;
   assign ex_rs1_data = rs1_data_q;
   assign ex_rs2_data = rs2_data_q;
   assign ex_imm      = imm_q;
   assign ex_rs1      = rs1_q;
   assign ex_rs2      = rs2_q;
   assign ex_rd       = rd_q;
   assign ex_ctrl     = ctrl_q;

endmodule

// File: tb/tb_id_ex_stall_reg.sv
// Directed table-driven bench for id_ex_stall_reg (3-bit stall counter instance).
module tb_id_ex_stall_reg;

   localparam logic [10:0] C1  = 11'h401;  // reg_write, alu_op=SUB
   localparam logic [10:0] C2  = 11'h2C0;  // mem_read, mem_to_reg, alu_src
   localparam logic [10:0] NOP = 11'h000;

   logic        clk, rst, id_valid, hazard_stall, flush;
   logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [10:0] id_ctrl;
   logic        ex_valid, ex_fire, stall_if_id;
   logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
   logic [4:0]  ex_rs1, ex_rs2, ex_rd;
   logic [10:0] ex_ctrl;
   logic [2:0]  stall_cycles;

   int checks = 0;
   int failures = 0;

   id_ex_stall_reg #(.XLEN(32), .ALUOP_W(4), .CNT_W(3)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .id_ctrl(id_ctrl), .hazard_stall(hazard_stall), .flush(flush),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
      .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
      .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl), .ex_fire(ex_fire),
      .stall_if_id(stall_if_id), .stall_cycles(stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst, vld, haz, fl;
      logic [31:0] pc;
      logic [4:0]  rd;
      logic [10:0] ctrl;
      logic        chk_comb, e_stall, e_fire;
      logic        e_vld;
      logic [31:0] e_pc;
      logic [4:0]  e_rd;
      logic [10:0] e_ctrl;
      logic [2:0]  e_cnt;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic v, input logic h, input logic f,
                        input logic [31:0] pc, input logic [4:0] rd, input logic [10:0] c);
      rst          = r;
      id_valid     = v;
      hazard_stall = h;
      flush        = f;
      id_pc        = pc;
      id_rd        = rd;
      id_rs1       = rd + 5'd1;
      id_rs2       = rd + 5'd2;
      id_rs1_data  = pc + 32'd1;
      id_rs2_data  = pc + 32'd2;
      id_imm       = ~pc;
      id_ctrl      = c;
   endtask

   // Data/index fields travel with pc/rd; a reset entry (pc=0) expects all zeros.
   task automatic check_regs(input string tag, input logic v, input logic [31:0] pc,
                             input logic [4:0] rd, input logic [10:0] c, input logic [2:0] cnt);
      logic z;
      z = (pc == 32'd0);
      chk({tag, ".ex_valid"}, 32'(ex_valid), 32'(v));
      chk({tag, ".ex_pc"}, ex_pc, pc);
      chk({tag, ".ex_rd"}, 32'(ex_rd), 32'(rd));
      chk({tag, ".ex_rs1"}, 32'(ex_rs1), z ? 32'd0 : 32'(5'(rd + 5'd1)));
      chk({tag, ".ex_rs2"}, 32'(ex_rs2), z ? 32'd0 : 32'(5'(rd + 5'd2)));
      chk({tag, ".ex_rs1_data"}, ex_rs1_data, z ? 32'd0 : pc + 32'd1);
      chk({tag, ".ex_rs2_data"}, ex_rs2_data, z ? 32'd0 : pc + 32'd2);
      chk({tag, ".ex_imm"}, ex_imm, z ? 32'd0 : ~pc);
      chk({tag, ".ex_ctrl"}, 32'(ex_ctrl), 32'(c));
      chk({tag, ".stall_cycles"}, 32'(stall_cycles), 32'(cnt));
   endtask

   task automatic check_comb(input string tag, input logic s, input logic f);
      chk({tag, ".stall_if_id"}, 32'(stall_if_id), 32'(s));
      chk({tag, ".ex_fire"}, 32'(ex_fire), 32'(f));
   endtask

   initial begin
      //          rst vld haz fl  pc          rd  ctrl cc st fi  vld e_pc       rd  ctrl cnt
      vecs[0]  = '{1, 1, 0, 0, 32'h100, 5, C1, 0, 0, 0, 0, 32'h000, 0, NOP, 0};
      vecs[1]  = '{1, 1, 1, 1, 32'h100, 5, C1, 1, 0, 0, 0, 32'h000, 0, NOP, 0};
      vecs[2]  = '{0, 1, 0, 0, 32'h100, 5, C1, 1, 0, 0, 1, 32'h100, 5, C1,  0};
      vecs[3]  = '{0, 1, 1, 0, 32'h104, 6, C2, 1, 1, 0, 1, 32'h100, 5, C1,  1};
      vecs[4]  = '{0, 1, 1, 0, 32'h104, 6, C2, 1, 1, 0, 1, 32'h100, 5, C1,  2};
      vecs[5]  = '{0, 1, 0, 0, 32'h104, 6, C2, 1, 0, 1, 1, 32'h104, 6, C2,  2};
      vecs[6]  = '{0, 1, 1, 1, 32'h108, 7, C1, 1, 0, 0, 0, 32'h104, 6, NOP, 2};
      vecs[7]  = '{0, 1, 1, 0, 32'h10C, 8, C2, 1, 0, 0, 1, 32'h10C, 8, C2,  2};
      vecs[8]  = '{0, 0, 0, 0, 32'h110, 9, C1, 1, 0, 1, 0, 32'h110, 9, NOP, 2};
      vecs[9]  = '{0, 1, 0, 0, 32'h114, 0, C1, 1, 0, 0, 1, 32'h114, 0, C1,  2};
      vecs[10] = '{0, 1, 0, 1, 32'h118, 3, C2, 1, 0, 0, 0, 32'h114, 0, NOP, 2};

      for (int unsigned i = 0; i < 11; i++) begin
         drive(vecs[i].rst, vecs[i].vld, vecs[i].haz, vecs[i].fl,
               vecs[i].pc, vecs[i].rd, vecs[i].ctrl);
         #1;
         if (vecs[i].chk_comb)
            check_comb($sformatf("v%0d", i), vecs[i].e_stall, vecs[i].e_fire);
         @(posedge clk);
         #1;
         check_regs($sformatf("v%0d", i), vecs[i].e_vld, vecs[i].e_pc,
                    vecs[i].e_rd, vecs[i].e_ctrl, vecs[i].e_cnt);
      end

      // Saturation: fresh reset, load one entry, then hold it stalled for 9 cycles.
      drive(1, 0, 0, 0, 32'h0, 0, NOP);
      @(posedge clk); #1;
      check_regs("sat_rst", 0, 32'h0, 0, NOP, 0);
      drive(0, 1, 0, 0, 32'h200, 3, C1);
      @(posedge clk); #1;
      check_regs("sat_load", 1, 32'h200, 3, C1, 0);
      for (int unsigned k = 1; k <= 9; k++) begin
         drive(0, 1, 1, 0, 32'h300, 4, C2);
         #1;
         check_comb($sformatf("sat%0d", k), 1, 0);
         @(posedge clk); #1;
         check_regs($sformatf("sat%0d", k), 1, 32'h200, 3, C1, (k > 7) ? 3'd7 : 3'(k));
      end

      // Reset arriving mid-stall drops the held entry and clears the counter.
      drive(1, 1, 1, 0, 32'h300, 4, C2);
      @(posedge clk); #1;
      check_regs("rst_mid_stall", 0, 32'h0, 0, NOP, 0);
      drive(0, 1, 1, 0, 32'h400, 10, C2);
      #1;
      check_comb("post_rst", 0, 0);
      @(posedge clk); #1;
      check_regs("post_rst", 1, 32'h400, 10, C2, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/id_ex_stall_reg.md
Name: id_ex_stall_reg

Overview:
- ID/EX pipeline register of the RV32I 5-stage core; it holds the decoded instruction presented to EX.
- Its rs1/rs2/rd/valid outputs feed the hazard detection unit, and it consumes the resulting hazard_stall.
- On a stall it holds its entry, tells IF/ID and PC to freeze, and presents a bubble downstream.
- It also applies pipeline flushes and counts stall cycles for performance monitoring.

Parameters:
- XLEN, 32, datapath width (pc, operands, immediate).
- ALUOP_W, 4, ALU operation code width.
- CNT_W, 32, stall cycle counter width.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  decode stage holds a real instruction.
- id_pc  in  XLEN  instruction PC.
- id_rs1, id_rs2, id_rd  in  5 each  register indices.
- id_rs1_data, id_rs2_data  in  XLEN each  register file read data.
- id_imm  in  XLEN  sign-extended immediate.
- id_ctrl  in  CTRL_W  packed control bundle: reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, jump, alu_op.
- hazard_stall  in  1  from the hazard detection unit.
- flush  in  1  branch/jump redirect from a later stage.
- ex_valid  out  1  ID/EX entry is a real instruction.
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN  registered fields.
- ex_rs1, ex_rs2, ex_rd  out  5  registered indices; rs1/rs2 go to the hazard unit.
- ex_ctrl  out  CTRL_W  registered control bundle.
- ex_fire  out  1  entry advances into EX/MEM this cycle.
- stall_if_id  out  1  hold PC and IF/ID.
- stall_cycles  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Reset (rst=1 at edge):
  - ex_valid=0, all data/index fields=0, ex_ctrl=CTRL_NOP (all write/mem enables 0).
  - stall_cycles=0.
  - Reset overrides flush and stall. A reset during an active stall drops the held entry.
- Combinational outputs:
  - stall_if_id = hazard_stall & ex_valid & ~flush.
  - ex_fire = ex_valid & ~hazard_stall & ~flush.
  - Downstream EX/MEM must capture ex_ctrl gated by ex_fire: a stalled cycle is a bubble.
- Update priority per edge: rst > flush > stall > load.
  - flush=1: ex_valid<=0, ex_ctrl<=CTRL_NOP, other fields don't-care (kept at their old values). The IF/ID flush is handled externally.
  - Stall (hazard_stall=1, ex_valid=1, flush=0): hold every field unchanged, hold the entry in ID/EX, stall_cycles++.
  - hazard_stall=1 with ex_valid=0 is ignored, because the entry is a bubble. The register loads normally and the counter does not increment.
  - Otherwise load: ex_*<=id_*, ex_valid<=id_valid. When id_valid=0, ex_ctrl<=CTRL_NOP.
- Latency: one cycle from id_* to ex_*. A stall adds one cycle per asserted cycle, with no limit; an unresolved dependency stalls for at most 2 cycles.
- Counter: saturates at 2^CNT_W-1 and does not wrap. It is cleared only by rst.
- ex_rd=0 with reg_write=1 passes through unchanged; the hazard unit already ignores x0.
- The stall decision depends only on registered ex_* outputs, so there is no combinational loop.

Decomposition:
- Package core_pkg holds:
  - ctrl_t field offsets and CTRL_W (= 7 + ALUOP_W).
  - CTRL_NOP constant.
  - ALU op encodings.
- Sub-module stall_counter: saturating counter with an inc enable. It is parameterised by CNT_W.

Test Plan:
1. Reset: assert rst for 2 cycles with id_valid=1 -> ex_valid=0, ex_ctrl=CTRL_NOP, stall_cycles=0.
2. Normal flow: load pc=0x100, rd=5, reg_write=1 -> next cycle ex_pc=0x100, ex_rd=5, ex_fire=1, stall_if_id=0.
3. Stall: entry valid, hazard_stall=1 for 2 cycles while id_pc changes to 0x104 -> ex_pc stays 0x100, stall_if_id=1 and ex_fire=0 for both cycles, stall_cycles=2; entry advances on the third cycle.
4. Flush during stall: hazard_stall=1 and flush=1 together -> ex_valid=0, ex_ctrl=CTRL_NOP next cycle, stall_if_id=0, counter unchanged.
5. Stall on bubble: ex_valid=0, hazard_stall=1 -> next id_* loads, stall_cycles unchanged.
6. Saturation: CNT_W=3, 9 stall cycles -> stall_cycles=7. Then rst mid-stall -> counter=0, ex_valid=0.
